sprite_render: RTL and testbench
================================

SPRITE_RENDER -- requirements
Module: sprite_render

Interface
REQ-001 SHALL have parameter SPR_W, default 64, sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 64, sprite height in pixels.
REQ-003 SHALL have parameter IDX_W, default 3, palette index width.
REQ-004 SHALL have parameter FRAMES, default 4, animation frames stored back-to-back in ROM.
REQ-005 SHALL have parameter FRAME_DIV, default 8, vsync periods per animation step.
REQ-006 SHALL have parameter TRANSP_IDX, default 0, index rendered as transparent.
REQ-007 SHALL have one clock and an asynchronous active-low reset: vga_clk  in  1  pixel clock, all logic on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: draw_x  in  10  current pixel column; draw_y  in  10  current pixel row.
REQ-009 SHALL have ports: blank  in  1  high = active video; vsync  in  1  active-low vertical sync.
REQ-010 SHALL have ports: pos_x  in  10, pos_y  in  10  sprite top-left; flip_h  in  1  horizontal mirror; anim_en  in  1  advance animation.
REQ-011 SHALL have ports: bg_red, bg_green, bg_blue  in  4 each  background colour.
REQ-012 SHALL have ports: rom_addr  out  ADDR_W = clog2(FRAMES*SPR_W*SPR_H)  ROM address; rom_q  in  IDX_W  ROM data, registered 1 cycle after rom_addr.
REQ-013 SHALL have ports: pal_idx  out  IDX_W  palette lookup index; pal_red, pal_green, pal_blue  in  4 each  combinational palette result.
REQ-014 SHALL have ports: red, green, blue  out  4 each  registered pixel; frame_idx  out  clog2(FRAMES)  current frame.

Function
REQ-015 SHALL register pos_x, pos_y and flip_h into shadow registers only on vsync falling edge (vsync registered, edge = prev 1, now 0), so the sprite never tears mid-frame.
REQ-016 SHALL compute hit as shadow_x <= draw_x < shadow_x+SPR_W and likewise for y, using 11-bit arithmetic so no wrap at 1023.
REQ-017 SHALL form col = draw_x-shadow_x, or SPR_W-1-(draw_x-shadow_x) when shadow flip_h=1; row = draw_y-shadow_y.
REQ-018 SHALL drive rom_addr = frame_idx*SPR_W*SPR_H + row*SPR_W + col, registered at cycle N+1 for draw inputs at cycle N; hit and blank delayed to match.
REQ-019 SHALL drive pal_idx = rom_q combinationally (cycle N+2).
REQ-020 SHALL register at cycle N+3: 0 if delayed blank=0; else bg colour if delayed hit=0 or rom_q==TRANSP_IDX; else pal colour. Total latency exactly 3 cycles.
REQ-021 SHALL count vsync falling edges while anim_en=1; on count reaching FRAME_DIV-1 SHALL clear count and increment frame_idx, wrapping FRAMES-1 -> 0.
REQ-022 SHALL hold divider count and frame_idx while anim_en=0; re-asserting anim_en resumes from the held count.
REQ-023 SHALL treat FRAMES=1 as frame_idx constant 0.

Reset
REQ-024 SHALL, while rst_n=0, clear red/green/blue, rom_addr, frame_idx, divider, shadow registers, vsync history and all pipeline hit/blank stages to 0 immediately, independent of vga_clk.
REQ-025 SHALL, after rst_n release mid-line, output only 0 or background until the pipeline refills (3 cycles); no stale sprite pixel SHALL appear.

Configuration
REQ-026 SHALL, with macro SPRITE_SCALE2X_EN defined, double the sprite: hit region 2*SPR_W x 2*SPR_H, col and row offsets shifted right by 1 before flip/addressing; flip uses SPR_W-1-(offset>>1).
REQ-027 SHALL, without SPRITE_SCALE2X_EN, render at 1:1 with behaviour per REQ-016..REQ-017; latency 3 cycles in both builds.

Verification
REQ-028 pos=(100,50), draw=(100,50), blank=1, rom_q=5, pal=(F,0,0) -> rom_addr=0 at N+1, red/green/blue=F,0,0 at N+3.
REQ-029 draw=(163,113), flip_h=1 latched -> rom_addr=SPR_W*63+0=4032; draw_x=164 -> hit=0, output = bg colour.
REQ-030 rom_q=TRANSP_IDX inside sprite, bg=(1,2,3) -> output 1,2,3; blank=0 same pixel -> 0,0,0.
REQ-031 anim_en=1, 8 vsync falls -> frame_idx 0->1; 32 falls -> wraps to 0; anim_en=0 for 5 falls -> frame_idx unchanged.
REQ-032 pos_x changed mid-frame -> hit region unchanged until next vsync fall; rst_n pulse mid-line -> outputs 0 asynchronously, frame_idx=0.
REQ-033 SPRITE_SCALE2X_EN build, pos=(0,0), draw=(3,5) -> rom_addr=2*SPR_W+1=129; draw=(127,0) hit, (128,0) miss.

Source files
------------

// File: rtl/sprite_render.sv
// Sprite overlay for a scan-out pipeline: a 3-cycle path of hit test, ROM address, palette and pixel mux.
// Define SPRITE_SCALE2X_EN to draw the sprite at twice its size.
module sprite_render #(
  parameter int unsigned SPR_W      = 64,
  parameter int unsigned SPR_H      = 64,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned FRAMES     = 4,
  parameter int unsigned FRAME_DIV  = 8,
  parameter int unsigned TRANSP_IDX = 0,
  localparam int unsigned ADDR_W    = $clog2(FRAMES * SPR_W * SPR_H),
  localparam int unsigned FI_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              blank,
  input  logic              vsync,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip_h,
  input  logic              anim_en,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_idx,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [FI_W-1:0]   frame_idx
);

  localparam int unsigned DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned FRAME_SZ = SPR_W * SPR_H;
`ifdef SPRITE_SCALE2X_EN
  localparam int unsigned HIT_W = 2 * SPR_W;
  localparam int unsigned HIT_H = 2 * SPR_H;
`else
  localparam int unsigned HIT_W = SPR_W;
  localparam int unsigned HIT_H = SPR_H;
`endif

  logic [9:0]        shx_q, shx_d, shy_q, shy_d;
  logic              shflip_q, shflip_d;
  logic              vsync_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [FI_W-1:0]   frame_q, frame_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hit1_q, blank1_q, hit2_q, blank2_q;
  logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic              vs_fall;
  logic              hit;
  logic [10:0]       x11, y11, sx11, sy11, dx, dy, off_x, off_y, col;

  assign vs_fall = vsync_q & ~vsync;

  // Position/flip shadows and the animation divider move only on vsync fall.
  always_comb begin
    shx_d    = shx_q;
    shy_d    = shy_q;
    shflip_d = shflip_q;
    div_d    = div_q;
    frame_d  = frame_q;
    if (vs_fall) begin
      shx_d    = pos_x;
      shy_d    = pos_y;
      shflip_d = flip_h;
      if (anim_en) begin
        if (div_q == DIV_W'(FRAME_DIV - 1)) begin
          div_d   = '0;
          frame_d = (frame_q == FI_W'(FRAMES - 1)) ? '0 : frame_q + FI_W'(1);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    end
    if (FRAMES == 1) frame_d = '0;
  end

  // 11-bit compare keeps a sprite near column 1023 from wrapping to column 0.
  always_comb begin
    x11  = {1'b0, draw_x};
    y11  = {1'b0, draw_y};
    sx11 = {1'b0, shx_q};
    sy11 = {1'b0, shy_q};
    dx   = x11 - sx11;
    dy   = y11 - sy11;
`ifdef SPRITE_SCALE2X_EN
    off_x = dx >> 1;
    off_y = dy >> 1;
`else
    off_x = dx;
    off_y = dy;
`endif
    col    = shflip_q ? (11'(SPR_W - 1) - off_x) : off_x;
    hit    = (x11 >= sx11) && (x11 < sx11 + 11'(HIT_W)) &&
             (y11 >= sy11) && (y11 < sy11 + 11'(HIT_H));
    addr_d = ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ) +
             ADDR_W'(off_y) * ADDR_W'(SPR_W) + ADDR_W'(col);
  end

  assign pal_idx = rom_q;

  // Final pixel mux, fed by the hit/blank stages aligned with rom_q.
  always_comb begin
    red_d   = 4'h0;
    green_d = 4'h0;
    blue_d  = 4'h0;
    if (blank2_q) begin
      if (!hit2_q || (rom_q == IDX_W'(TRANSP_IDX))) begin
        red_d   = bg_red;
        green_d = bg_green;
        blue_d  = bg_blue;
      end else begin
        red_d   = pal_red;
        green_d = pal_green;
        blue_d  = pal_blue;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      shx_q    <= '0;
      shy_q    <= '0;
      shflip_q <= 1'b0;
      vsync_q  <= 1'b0;
      div_q    <= '0;
      frame_q  <= '0;
      addr_q   <= '0;
      hit1_q   <= 1'b0;
      blank1_q <= 1'b0;
      hit2_q   <= 1'b0;
      blank2_q <= 1'b0;
      red_q    <= 4'h0;
      green_q  <= 4'h0;
      blue_q   <= 4'h0;
    end else begin
      shx_q    <= shx_d;
      shy_q    <= shy_d;
      shflip_q <= shflip_d;
      vsync_q  <= vsync;
      div_q    <= div_d;
      frame_q  <= frame_d;
      addr_q   <= addr_d;
      hit1_q   <= hit;
      blank1_q <= blank;
      hit2_q   <= hit1_q;
      blank2_q <= blank1_q;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

  assign rom_addr  = addr_q;
  assign frame_idx = frame_q;
  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;

endmodule

// File: tb/tb_sprite_render.sv
// Directed bench for sprite_render: vector table plus animation, shadow-latch and reset sequences.
module tb_sprite_render;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned FI_W   = 2;

  logic              vga_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [9:0]        draw_x = '0, draw_y = '0, pos_x = '0, pos_y = '0;
  logic              blank = 1'b0, vsync = 1'b1, flip_h = 1'b0, anim_en = 1'b0;
  logic [3:0]        bg_red = 4'h1, bg_green = 4'h2, bg_blue = 4'h3;
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        rom_q = '0;
  logic [2:0]        pal_idx;
  logic [3:0]        pal_red, pal_green, pal_blue;
  logic [3:0]        red, green, blue;
  logic [FI_W-1:0]   frame_idx;
  logic [11:0]       rgb;

  logic              frc_en = 1'b0;
  logic [2:0]        frc_val = '0;
  int                n_cmp = 0;
  int                n_fail = 0;

  typedef struct {
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        bl;
    logic        fl;
    logic        frc;
    logic [2:0]  fv;
    logic        ca;
    logic [13:0] ea;
    logic [11:0] ergb;
  } vec_t;

  sprite_render #(
    .SPR_W(64), .SPR_H(64), .IDX_W(3), .FRAMES(4), .FRAME_DIV(8), .TRANSP_IDX(0)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .draw_x(draw_x), .draw_y(draw_y),
    .blank(blank), .vsync(vsync), .pos_x(pos_x), .pos_y(pos_y),
    .flip_h(flip_h), .anim_en(anim_en), .bg_red(bg_red), .bg_green(bg_green),
    .bg_blue(bg_blue), .rom_addr(rom_addr), .rom_q(rom_q), .pal_idx(pal_idx),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .frame_idx(frame_idx)
  );

  always #5 vga_clk = ~vga_clk;

  // ROM: low address bits as the index unless a vector forces a value.
  always @(posedge vga_clk) rom_q <= frc_en ? frc_val : rom_addr[2:0];

  function automatic logic [11:0] pal_fn(input logic [2:0] i);
    case (i)
      3'd1:    pal_fn = 12'h193;
      3'd2:    pal_fn = 12'h2A5;
      3'd3:    pal_fn = 12'h3B7;
      3'd4:    pal_fn = 12'h4C9;
      3'd5:    pal_fn = 12'hF00;
      3'd6:    pal_fn = 12'h6ED;
      3'd7:    pal_fn = 12'h7FF;
      default: pal_fn = 12'h000;
    endcase
  endfunction

  assign {pal_red, pal_green, pal_blue} = pal_fn(pal_idx);
  assign rgb = {red, green, blue};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic vs_fall();
    @(negedge vga_clk) vsync = 1'b1;
    @(negedge vga_clk) vsync = 1'b0;
    @(negedge vga_clk) vsync = 1'b1;
  endtask

  task automatic latch(input logic [9:0] px, input logic [9:0] py, input logic fl);
    pos_x  = px;
    pos_y  = py;
    flip_h = fl;
    vs_fall();
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge vga_clk);
    draw_x  = v.dx;
    draw_y  = v.dy;
    blank   = v.bl;
    frc_en  = v.frc;
    frc_val = v.fv;
    @(negedge vga_clk);
    if (v.ca) chk({nm, "_addr"}, 32'(rom_addr), 32'(v.ea));
    @(negedge vga_clk);
    @(negedge vga_clk);
    chk({nm, "_rgb"}, 32'(rgb), 32'(v.ergb));
  endtask

  vec_t tbl[15];
  vec_t sc[5];
  vec_t v;
  logic cur_fl;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{10'd100, 10'd50,  1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 14'd0,    12'hF00};
    tbl[1]  = '{10'd100, 10'd50,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 14'd0,    12'h123};
    tbl[2]  = '{10'd163, 10'd113, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 14'd4095, 12'h7FF};
    tbl[3]  = '{10'd101, 10'd50,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 14'd1,    12'h193};
    tbl[4]  = '{10'd99,  10'd50,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 14'd0,    12'h123};
    tbl[5]  = '{10'd164, 10'd50,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 14'd0,    12'h123};
    tbl[6]  = '{10'd100, 10'd114, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 14'd0,    12'h123};
    tbl[7]  = '{10'd100, 10'd50,  1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 14'd0,    12'h000};
    tbl[8]  = '{10'd130, 10'd60,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 14'd670,  12'h6ED};
    tbl[9]  = '{10'd110, 10'd49,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 14'd0,    12'h123};
    tbl[10] = '{10'd163, 10'd113, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 14'd4032, 12'hF00};
    tbl[11] = '{10'd164, 10'd113, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 14'd0,    12'h123};
    tbl[12] = '{10'd100, 10'd50,  1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 14'd63,   12'h7FF};
    tbl[13] = '{10'd101, 10'd50,  1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 14'd62,   12'h6ED};
    tbl[14] = '{10'd163, 10'd50,  1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 14'd0,    12'h123};

    sc[0] = '{10'd3,   10'd5,   1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 14'd129,  12'hF00};
    sc[1] = '{10'd127, 10'd0,   1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 14'd63,   12'hF00};
    sc[2] = '{10'd128, 10'd0,   1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 14'd0,    12'h123};
    sc[3] = '{10'd0,   10'd127, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 14'd4032, 12'hF00};
    sc[4] = '{10'd0,   10'd128, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 14'd0,    12'h123};

    repeat (3) @(negedge vga_clk);
    chk("reset_rgb", 32'(rgb), 32'h0);
    chk("reset_addr", 32'(rom_addr), 32'h0);
    chk("reset_frame", 32'(frame_idx), 32'h0);
    rst_n = 1'b1;

`ifdef SPRITE_SCALE2X_EN
    latch(10'd0, 10'd0, 1'b0);
    for (int i = 0; i < 5; i++) apply(sc[i], $sformatf("scale%0d", i));
`else
    latch(10'd100, 10'd50, 1'b0);
    cur_fl = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].fl != cur_fl) begin
        latch(10'd100, 10'd50, tbl[i].fl);
        cur_fl = tbl[i].fl;
      end
      apply(tbl[i], $sformatf("vec%0d", i));
    end
`endif

    // Position change between vsync falls must not move the sprite.
    latch(10'd100, 10'd50, 1'b0);
    v = '{10'd100, 10'd50, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 14'd0, 12'hF00};
    apply(v, "pos_before");
    pos_x = 10'd200;
    apply(v, "pos_midframe");
    vs_fall();
    v = '{10'd100, 10'd50, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 14'd0, 12'h123};
    apply(v, "pos_old_miss");
    v = '{10'd200, 10'd50, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 14'd0, 12'hF00};
    apply(v, "pos_new_hit");
    latch(10'd100, 10'd50, 1'b0);

    // Animation divider: 8 falls per step, wrap after 4 frames, hold while disabled.
    anim_en = 1'b1;
    repeat (7) vs_fall();
    chk("anim_7falls", 32'(frame_idx), 32'd0);
    vs_fall();
    chk("anim_8falls", 32'(frame_idx), 32'd1);
    v = '{10'd100, 10'd50, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 14'd4096, 12'hF00};
    apply(v, "anim_frame1");
    repeat (23) vs_fall();
    chk("anim_31falls", 32'(frame_idx), 32'd3);
    vs_fall();
    chk("anim_wrap", 32'(frame_idx), 32'd0);
    repeat (3) vs_fall();
    anim_en = 1'b0;
    repeat (5) vs_fall();
    chk("anim_hold", 32'(frame_idx), 32'd0);
    anim_en = 1'b1;
    repeat (4) vs_fall();
    chk("anim_resume4", 32'(frame_idx), 32'd0);
    vs_fall();
    chk("anim_resume5", 32'(frame_idx), 32'd1);
    anim_en = 1'b0;

    // Asynchronous reset in the middle of a sprite line.
    v = '{10'd100, 10'd50, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 14'd4096, 12'hF00};
    apply(v, "pre_reset");
    @(negedge vga_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", 32'(rgb), 32'h0);
    chk("async_rst_addr", 32'(rom_addr), 32'h0);
    chk("async_rst_frame", 32'(frame_idx), 32'h0);
    @(negedge vga_clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge vga_clk);
      n_cmp++;
      if (!(rgb == 12'h000 || rgb == 12'h123)) begin
        n_fail++;
        $display("FAIL refill%0d: got %0h expected 0 or 123", i, rgb);
      end
    end
    chk("refill_bg", 32'(rgb), 32'h123);
    v = '{10'd0, 10'd0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 14'd0, 12'hF00};
    apply(v, "post_reset_shadow");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
